// File: rtl/pattern_detector_52_pkg.sv
// pd52_pkg: shared state encoding and reference pattern for the 110100 detector
package pd52_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S1     = 3'd1,
    S11    = 3'd2,
    S110   = 3'd3,
    S1101  = 3'd4,
    S11010 = 3'd5,
    DET    = 3'd6
  } state_t;
  localparam logic [5:0] PATTERN = 6'b110100;
endpackage

// File: rtl/pattern_detector_52.sv
// pattern_detector_52: Moore detector for serial sequence 110100, one-cycle y pulse
module pattern_detector_52
  import pd52_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic x,
  output logic y
);
  state_t state, next;
  // state register; rstn is an active-high synchronous reset
  always_ff @(posedge clk)
    if (rstn) state <= IDLE;
    else      state <= next;
  // next-state: longest suffix of the received bits that is still a pattern prefix
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = x ? S1    : IDLE;
      S1:      next = x ? S11   : IDLE;
      S11:     next = x ? S11   : S110;
      S110:    next = x ? S1101 : IDLE;
      S1101:   next = x ? S11   : S11010;
      S11010:  next = x ? S1    : DET;
      DET:     next = x ? S1    : IDLE;
      default: next = IDLE;
    endcase
  end
  assign y = state == DET;
endmodule

// File: tb/tb_pattern_detector_52.sv
// tb_pattern_detector_52: directed and random checks against a shift-register model
module tb_pattern_detector_52;
  import pd52_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic x = 1'b0;
  logic y;
  int tests = 0;
  int fails = 0;
  int hits = 0;
  logic [5:0] sh = '0;
  logic exp_q[$];
  pattern_detector_52 dut (.clk(clk), .rstn(rstn), .x(x), .y(y));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end
  task automatic step(input logic b, input logic r, input string tag);
    logic e;
    @(negedge clk);
    x = b;
    rstn = r;
    if (r) sh = '0;
    else sh = {sh[4:0], b};
    exp_q.push_back(!r && sh == PATTERN);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (y === 1'b1) hits++;
    tests++;
    assert (y === e) else begin
      fails++;
      $error("FAIL %s: y=%b expected %b", tag, y, e);
    end
  endtask
  task automatic bits(input logic [15:0] v, input int n, input string tag);
    for (int i = 0; i < n; i++) step(v[n-1-i], 1'b0, tag);
  endtask
  task automatic check_hits(input int want, input string tag);
    tests++;
    assert (hits === want) else begin
      fails++;
      $error("FAIL %s: pulses=%0d expected %0d", tag, hits, want);
    end
    hits = 0;
  endtask
  initial begin
    step(1'b1, 1'b1, "reset_hold");
    step(1'b1, 1'b1, "reset_hold");
    hits = 0;
    bits(16'b11010, 5, "partial");
    check_hits(0, "partial_pulses");
    step(1'b0, 1'b1, "reset");
    hits = 0;
    bits(16'b1100110100, 10, "basic");
    check_hits(1, "basic_pulses");
    step(1'b0, 1'b1, "reset");
    hits = 0;
    bits(16'b1110100110, 10, "run_of_ones");
    check_hits(1, "run_of_ones_pulses");
    step(1'b0, 1'b1, "reset");
    hits = 0;
    bits(16'b110110100, 9, "suffix_11");
    check_hits(1, "suffix_11_pulses");
    step(1'b0, 1'b1, "reset");
    hits = 0;
    bits(16'b110100110100, 12, "back_to_back");
    check_hits(2, "back_to_back_pulses");
    step(1'b0, 1'b1, "reset");
    hits = 0;
    bits(16'b11010100, 8, "no_detect");
    check_hits(0, "no_detect_pulses");
    step(1'b0, 1'b1, "reset");
    hits = 0;
    bits(16'b11010, 5, "mid_match");
    step(1'b0, 1'b1, "reset_on_final");
    check_hits(0, "reset_drop_pulses");
    bits(16'b110100, 6, "after_reset");
    check_hits(1, "after_reset_pulses");
    for (int i = 0; i < 80; i++) step(1'($urandom_range(0, 1)), 1'b0, "random");
    tests++;
    assert (exp_q.size() === 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: left=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pattern_detector_52.md
Name: pattern_detector_52

Overview:
- Serial, non-resettable-pattern bit-stream detector for the 6-bit sequence 1-1-0-1-0-0 (first bit received first).
- One bit of `x` is sampled per rising edge of `clk`.
- Moore FSM: registered one-hot-free encoded state; `y` is decoded from state only.
- Sits on a serial input path as a leaf block; its output pulse feeds downstream control logic.

Parameters:
- none (pattern fixed at 110100; state width 3 bits)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  synchronous reset, ACTIVE-HIGH despite the name (rstn=1 at a rising edge resets the block)
- x  input  1  serial data bit, sampled on each rising edge of clk
- y  output  1  detect flag, high for exactly one cycle after the final 0 of 110100 is sampled

Behaviour:
- Reset: synchronous, active-high on rstn.
  - On a rising edge with rstn=1: state <= IDLE, so y=0 from that edge on.
  - Reset overrides any in-progress match. A detection that would complete on that edge is dropped.
- States (3-bit encoding):
  - IDLE=0, S1=1, S11=2, S110=3, S1101=4, S11010=5, DET=6.
  - Code 7 is unused and recovers to IDLE on the next edge.
- Transitions on each rising edge (rstn=0), written as "x=0 -> next, x=1 -> next":
  - IDLE: 0->IDLE, 1->S1
  - S1: 0->IDLE, 1->S11
  - S11: 0->S110, 1->S11 (runs of 1s keep S11)
  - S110: 0->IDLE, 1->S1101
  - S1101: 0->S11010, 1->S11 (11011 keeps suffix 11)
  - S11010: 0->DET, 1->S1 (110101 keeps suffix 1)
  - DET: 0->IDLE, 1->S1
- Overlap: overlapping detection is supported via the suffix/prefix transitions above. No proper suffix of 110100 is a prefix of it, so back-to-back detections are at least 6 bits apart.
- Output: y = (state == DET), purely decoded from the state register with no combinational path from x.
  - Latency: y rises on the same rising edge that samples the 6th pattern bit (the final 0).
  - y stays high for exactly one clk period, then falls unless reset intervenes.
- No enable and no handshake. Every clock edge consumes one bit.
- X on x: the implementation is not required to handle it. The bench drives only 0/1.

Decomposition:
- Shared package pd52_pkg holds:
  - the state enum (IDLE..DET, 3-bit), and
  - localparam PATTERN = 6'b110100 for bench reference-model use.
- No sub-module. The next-state logic and output decode live in the one module, with the state register in a single clocked process.

Test Plan:
- Reset: hold rstn=1 for 2 edges while driving x=1 -> y=0. Release rstn, drive 1,1,0,1,0 -> y stays 0.
- Basic detect: drive 1,1,0,0,1,1,0,1,0,0 on successive edges -> y=1 only in the cycle after the 10th edge, 0 everywhere else.
- Run of 1s and recovery: drive 1,1,1,0,1,0,0,1,1,0 -> y=1 for one cycle after the 7th edge, 0 after the 8th. Also drive 1,1,0,1,1,0,1,0,0 -> single detect after the 9th edge.
- Back-to-back: drive 110100110100 -> exactly two one-cycle pulses, after edges 6 and 12. Drive 11010100 -> no detect.
- Reset mid-match: drive 1,1,0,1,0, then assert rstn=1 on the edge carrying the final 0 -> y stays 0. Release and drive 110100 -> pulse after its 6th edge.
- Random: 50+ random bits checked against a shift-register reference model (last 6 samples == PATTERN implies y=1 next cycle) -> zero mismatches.
